// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package cpu_pkg;

  // Responder handshake sequencing
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } dmem_state_t;

  // Offsets of the memory-mapped I/O registers from IO_BASE
  localparam logic [31:0] IO_LED_OFS  = 32'd0;
  localparam logic [31:0] IO_STAT_OFS = 32'd4;

endpackage

// File: rtl/cpu_dmem_responder_if.sv
// CPU data-memory bus: request side driven by the CPU, response side by the responder.
interface cpu_dmem_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, one 32-bit word per index, read-first.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_reg [0:DEPTH-1];

  // Registered read every cycle; write when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[idx] <= wdata;
    end
    rdata <= mem_reg[idx];
  end

endmodule

// File: rtl/cpu_dmem_responder.sv
// Responder end of the CPU data-memory bus: decodes RAM / LED / status space,
// inserts programmable wait states and answers with a one-cycle ready pulse.
module cpu_dmem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] IO_BASE     = 32'h0000_0400
) (
  input  logic                 clkFPGA,
  input  logic                 rst,
  cpu_dmem_responder_if.slave  bus,
  input  logic [7:0]           io_in,
  output logic [7:0]           io_out
);

  import cpu_pkg::*;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  dmem_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic [7:0]  io_out_reg;
  logic [7:0]  io_meta_reg;
  logic [7:0]  io_sync_reg;
  logic [15:0] txn_cnt_reg;

  logic        accept;
  logic        in_resp;
  logic        misaligned;
  logic        hit_ram;
  logic        hit_led;
  logic        hit_stat;
  logic        bad_access;

  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   resp_data;

  assign accept  = (state_reg == S_IDLE) && bus.req;
  assign in_resp = (state_reg == S_RESP);

  // Decode always works on the latched address so late bus changes are harmless
  assign misaligned = (addr_reg[1:0] != 2'b00);
  assign hit_ram    = !misaligned && (addr_reg < RAM_LIMIT);
  assign hit_led    = !misaligned && !hit_ram && (addr_reg == IO_BASE + IO_LED_OFS);
  assign hit_stat   = !misaligned && !hit_ram && (addr_reg == IO_BASE + IO_STAT_OFS);
  assign bad_access = !(hit_ram || hit_led || hit_stat);

  // In IDLE the RAM is addressed from the live bus so that a zero-wait load
  // already has its word registered by the RESP cycle.
  assign ram_idx = (state_reg == S_IDLE) ? bus.addr[AW+1:2] : addr_reg[AW+1:2];
  assign ram_we  = in_resp && we_reg && hit_ram;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clkFPGA),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  // State and wait-counter registers
  always_ff @(posedge clkFPGA or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: IDLE -> WAIT (count down) -> RESP -> IDLE
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.req) begin
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Request capture, LED write commit and transaction counting
  always_ff @(posedge clkFPGA or negedge rst) begin
    if (!rst) begin
      we_reg      <= 1'b0;
      addr_reg    <= 32'h0;
      wdata_reg   <= 32'h0;
      io_out_reg  <= 8'h00;
      txn_cnt_reg <= 16'h0000;
    end else begin
      if (accept) begin
        we_reg    <= bus.we;
        addr_reg  <= bus.addr;
        wdata_reg <= bus.wdata;
      end
      if (in_resp) begin
        txn_cnt_reg <= txn_cnt_reg + 16'd1;
        if (we_reg && hit_led) begin
          io_out_reg <= wdata_reg[7:0];
        end
      end
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge clkFPGA or negedge rst) begin
    if (!rst) begin
      io_meta_reg <= 8'h00;
      io_sync_reg <= 8'h00;
    end else begin
      io_meta_reg <= io_in;
      io_sync_reg <= io_meta_reg;
    end
  end

  // Load data is selected only from registered sources and is zero outside RESP,
  // for stores, and for faulting accesses
  always_comb begin
    resp_data = 32'h0;
    if (in_resp && !we_reg) begin
      if (hit_ram) begin
        resp_data = ram_rdata;
      end else if (hit_led) begin
        resp_data = {24'h0, io_out_reg};
      end else if (hit_stat) begin
        resp_data = {io_sync_reg, 8'h00, txn_cnt_reg};
      end
    end
  end

  assign bus.ready = in_resp;
  assign bus.err   = in_resp && bad_access;
  assign bus.rdata = resp_data;
  assign io_out    = io_out_reg;

endmodule
